// File: rtl/cnt_dly_counter_core_if.sv
`default_nettype none
// ============================================================================
// Module      : cnt_dly_counter_core_if
// Description : Control/status bundle of the CNT/DLY2/FSM0 main counter stage.
//               master : mode/control side (drives i_*, observes o_*)
//               slave  : counter core (observes i_*, drives o_*)
//   i_reset_set_mode     : 0 = load 0 after reset, 1 = load preset D
//   i_data_from_register : preset / reload value D
//   i_is_dly_mode        : DLY function selected (priority over CNT)
//   i_is_cnt_mode        : CNT/FSM function selected
//   i_dly_allow          : DLY count enable, 0 clears the counter
//   i_up / i_keep        : FSM direction / hold request
//   o_counter            : registered counter value
//   o_zero / o_match     : counter == 0 / counter == D
//   o_wrap / o_loaded    : one-cycle overflow-reload / post-reset load pulses
//   o_keeping            : FSM currently holding in KEEP
// Revision    : 1.0 - initial release
// ============================================================================
interface cnt_dly_counter_core_if #(
  parameter int BIT_WIDTH = 14
);
  logic                 i_reset_set_mode;
  logic [BIT_WIDTH-1:0] i_data_from_register;
  logic                 i_is_dly_mode;
  logic                 i_is_cnt_mode;
  logic                 i_dly_allow;
  logic                 i_up;
  logic                 i_keep;
  logic [BIT_WIDTH-1:0] o_counter;
  logic                 o_zero;
  logic                 o_match;
  logic                 o_wrap;
  logic                 o_loaded;
  logic                 o_keeping;

  modport master (
    output i_reset_set_mode, i_data_from_register, i_is_dly_mode,
           i_is_cnt_mode, i_dly_allow, i_up, i_keep,
    input  o_counter, o_zero, o_match, o_wrap, o_loaded, o_keeping
  );

  modport slave (
    input  i_reset_set_mode, i_data_from_register, i_is_dly_mode,
           i_is_cnt_mode, i_dly_allow, i_up, i_keep,
    output o_counter, o_zero, o_match, o_wrap, o_loaded, o_keeping
  );
endinterface
`default_nettype wire

// File: rtl/cnt_dly_counter_core.sv
`default_nettype none
// ============================================================================
// Module      : cnt_dly_counter_core
// Description : Main counter stage of the CNT/DLY2/FSM0 macrocell. Loads the
//               preset (or 0) on the first clock after reset release, then
//               counts in DLY or CNT/FSM mode with wrap/reload, KEEP hold and
//               zero/match decodes for the downstream mode logic.
// Ports       : clk                - selected macrocell clock (posedge)
//               main_counter_reset - asynchronous active-low counter reset
//               bus                - control/status bundle (slave modport)
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_dly_counter_core #(
  parameter int BIT_WIDTH = 14
) (
  input  wire logic              clk,
  input  wire logic              main_counter_reset,
  cnt_dly_counter_core_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_ARMED = 2'd0,
    ST_RUN   = 2'd1,
    ST_KEEP  = 2'd2
  } state_t;

  localparam logic [BIT_WIDTH-1:0] c_zero     = '0;
  localparam logic [BIT_WIDTH-1:0] c_all_ones = '1;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIT_WIDTH-1:0] r_counter;
  logic [BIT_WIDTH-1:0] w_counter_nxt;
  logic                 r_wrap;
  logic                 w_wrap_nxt;
  logic                 r_loaded;
  logic                 w_loaded_nxt;
  logic                 w_is_zero;
  logic                 w_is_max;

  assign w_is_zero = (r_counter == c_zero);
  assign w_is_max  = (r_counter == c_all_ones);

  always_ff @(posedge clk or negedge main_counter_reset) begin
    if (!main_counter_reset) begin
      r_state   <= ST_ARMED;
      r_counter <= c_zero;
      r_wrap    <= 1'b0;
      r_loaded  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_counter <= w_counter_nxt;
      r_wrap    <= w_wrap_nxt;
      r_loaded  <= w_loaded_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_counter_nxt = r_counter;
    w_wrap_nxt    = 1'b0;
    w_loaded_nxt  = 1'b0;
    case (r_state)
      ST_ARMED: begin
        // Control inputs are deliberately ignored on the load edge.
        w_counter_nxt = bus.i_reset_set_mode ? bus.i_data_from_register : c_zero;
        w_loaded_nxt  = 1'b1;
        w_state_nxt   = ST_RUN;
      end
      default: begin
        // RUN and KEEP share one rule set: KEEP re-evaluates the RUN rule on
        // every edge so releasing i_keep takes effect without a dead cycle.
        w_state_nxt = ST_RUN;
        if (bus.i_is_dly_mode) begin
          if (bus.i_dly_allow) begin
            w_counter_nxt = r_counter + 1'b1;
            w_wrap_nxt    = w_is_max;
          end else begin
            w_counter_nxt = c_zero;
          end
        end else if (bus.i_is_cnt_mode) begin
          if (bus.i_up) begin
            if (bus.i_keep) begin
              w_state_nxt = ST_KEEP;
            end else begin
              w_counter_nxt = r_counter + 1'b1;
              w_wrap_nxt    = w_is_max;
            end
          end else if (w_is_zero) begin
            // Down-count reload has priority over a hold request.
            w_counter_nxt = bus.i_data_from_register;
            w_wrap_nxt    = 1'b1;
          end else if (bus.i_keep) begin
            w_state_nxt = ST_KEEP;
          end else begin
            w_counter_nxt = r_counter - 1'b1;
          end
        end
      end
    endcase
  end

  assign bus.o_counter = r_counter;
  assign bus.o_zero    = w_is_zero;
  assign bus.o_match   = (r_counter == bus.i_data_from_register);
  assign bus.o_wrap    = r_wrap;
  assign bus.o_loaded  = r_loaded;
  assign bus.o_keeping = (r_state == ST_KEEP);

endmodule
`default_nettype wire

// File: tb/tb_cnt_dly_counter_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_cnt_dly_counter_core
// Description : Directed self-checking bench for cnt_dly_counter_core with a
//               reference model feeding an expected-value queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cnt_dly_counter_core;
  localparam int BIT_WIDTH = 14;
  localparam logic [BIT_WIDTH-1:0] c_max = '1;

  typedef struct {
    logic [BIT_WIDTH-1:0] cnt;
    logic                 wrap;
    logic                 loaded;
    logic                 keeping;
  } exp_t;

  logic clk = 1'b0;
  logic main_counter_reset;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb_q[$];

  // Reference model state
  logic [BIT_WIDTH-1:0] m_cnt;
  logic                 m_armed;
  logic                 m_keep;
  logic                 m_wrap;
  logic                 m_loaded;

  cnt_dly_counter_core_if #(.BIT_WIDTH(BIT_WIDTH)) bus ();

  cnt_dly_counter_core #(.BIT_WIDTH(BIT_WIDTH)) dut (
    .clk                (clk),
    .main_counter_reset (main_counter_reset),
    .bus                (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e, input string where);
    logic [BIT_WIDTH-1:0] d;
    d = bus.i_data_from_register;
    chk({where, "_counter"}, 32'(bus.o_counter), 32'(e.cnt));
    chk({where, "_wrap"},    32'(bus.o_wrap),    32'(e.wrap));
    chk({where, "_loaded"},  32'(bus.o_loaded),  32'(e.loaded));
    chk({where, "_keeping"}, 32'(bus.o_keeping), 32'(e.keeping));
    chk({where, "_zero"},    32'(bus.o_zero),    32'(e.cnt == '0));
    chk({where, "_match"},   32'(bus.o_match),   32'(e.cnt == d));
  endtask

  // Predict the outcome of the next clock edge from the current inputs.
  task automatic model_edge();
    exp_t e;
    m_wrap   = 1'b0;
    m_loaded = 1'b0;
    if (!main_counter_reset) begin
      m_cnt = '0; m_armed = 1'b1; m_keep = 1'b0;
    end else if (m_armed) begin
      m_cnt    = bus.i_reset_set_mode ? bus.i_data_from_register : '0;
      m_loaded = 1'b1;
      m_armed  = 1'b0;
      m_keep   = 1'b0;
    end else if (bus.i_is_dly_mode) begin
      m_keep = 1'b0;
      if (bus.i_dly_allow) begin
        m_wrap = (m_cnt == c_max);
        m_cnt  = m_cnt + 1'b1;
      end else begin
        m_cnt = '0;
      end
    end else if (bus.i_is_cnt_mode) begin
      if (!bus.i_up && m_cnt == '0) begin
        m_cnt = bus.i_data_from_register; m_wrap = 1'b1; m_keep = 1'b0;
      end else if (bus.i_keep) begin
        m_keep = 1'b1;
      end else begin
        m_keep = 1'b0;
        if (bus.i_up) begin
          m_wrap = (m_cnt == c_max);
          m_cnt  = m_cnt + 1'b1;
        end else begin
          m_cnt = m_cnt - 1'b1;
        end
      end
    end else begin
      m_keep = 1'b0;
    end
    e.cnt = m_cnt; e.wrap = m_wrap; e.loaded = m_loaded; e.keeping = m_keep;
    sb_q.push_back(e);
  endtask

  task automatic cyc(input string where);
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk({where, "_queue_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check_outputs(e, where);
    end
  endtask

  task automatic check_now(input string where);
    exp_t e;
    e.cnt = m_cnt; e.wrap = m_wrap; e.loaded = m_loaded; e.keeping = m_keep;
    check_outputs(e, where);
  endtask

  task automatic set_rst(input logic v, input string where);
    main_counter_reset = v;
    if (!v) begin
      m_cnt = '0; m_armed = 1'b1; m_keep = 1'b0; m_wrap = 1'b0; m_loaded = 1'b0;
    end
    #2;
    check_now(where);
  endtask

  initial begin
    // Reset state
    bus.i_reset_set_mode     = 1'b1;
    bus.i_data_from_register = 14'd100;
    bus.i_is_dly_mode        = 1'b0;
    bus.i_is_cnt_mode        = 1'b1;
    bus.i_dly_allow          = 1'b0;
    bus.i_up                 = 1'b0;
    bus.i_keep               = 1'b0;
    set_rst(1'b0, "reset");
    cyc("reset_frozen");
    cyc("reset_frozen");

    // Preset load then count down
    set_rst(1'b1, "release");
    cyc("load100");
    chk("dir_load_pulse", 32'(bus.o_loaded), 32'd1);
    for (int i = 0; i < 4; i++) cyc("down100");
    chk("dir_cnt_96", 32'(bus.o_counter), 32'd96);

    // Down count with zero reset value, reload period of 4
    set_rst(1'b0, "rst2");
    bus.i_reset_set_mode     = 1'b0;
    bus.i_data_from_register = 14'd3;
    set_rst(1'b1, "rel2");
    cyc("load0");
    for (int i = 0; i < 9; i++) cyc("reload3");
    chk("dir_reload_wrap", 32'(bus.o_wrap), 32'd1);
    // Live D: match follows at once, reload picks up the new D later
    bus.i_data_from_register = 14'd2;
    #1;
    check_now("d_change");
    for (int i = 0; i < 4; i++) cyc("reload2");
    // Reset while o_wrap pulse is high drops it
    set_rst(1'b0, "rst_drop_wrap");

    // Up count across all-ones, keep at zero, then down reload from KEEP
    bus.i_reset_set_mode     = 1'b1;
    bus.i_data_from_register = 14'd16382;
    set_rst(1'b1, "rel3");
    cyc("load16382");
    bus.i_up = 1'b1;
    for (int i = 0; i < 2; i++) cyc("up_wrap");
    chk("dir_up_wrap", 32'(bus.o_wrap), 32'd1);
    bus.i_keep = 1'b1;
    cyc("keep_at0");
    bus.i_up = 1'b0;
    cyc("keep_reload");
    bus.i_keep = 1'b0;
    bus.i_up   = 1'b1;
    cyc("up_after");

    // KEEP hold and release in down direction
    set_rst(1'b0, "rst4");
    bus.i_up                 = 1'b0;
    bus.i_data_from_register = 14'd5;
    set_rst(1'b1, "rel4");
    cyc("load5");
    bus.i_keep = 1'b1;
    for (int i = 0; i < 3; i++) cyc("hold5");
    chk("dir_keeping", 32'(bus.o_keeping), 32'd1);
    bus.i_keep = 1'b0;
    cyc("release4");
    chk("dir_release4", 32'(bus.o_counter), 32'd4);
    for (int i = 0; i < 4; i++) cyc("down5");
    bus.i_keep = 1'b1;
    cyc("keep_vs_reload");
    cyc("keep_enter");
    bus.i_up = 1'b1;
    cyc("keep_up_hold");
    bus.i_is_cnt_mode = 1'b0;
    cyc("leave_cnt");
    bus.i_is_cnt_mode = 1'b1;
    bus.i_keep        = 1'b0;
    cyc("up_resume");

    // DLY mode has priority, keep ignored
    set_rst(1'b0, "rst5");
    bus.i_reset_set_mode = 1'b0;
    set_rst(1'b1, "rel5");
    cyc("load_dly");
    bus.i_is_dly_mode = 1'b1;
    bus.i_dly_allow   = 1'b1;
    bus.i_keep        = 1'b1;
    for (int i = 0; i < 10; i++) cyc("dly_count");
    chk("dir_dly_10", 32'(bus.o_counter), 32'd10);
    bus.i_dly_allow = 1'b0;
    cyc("dly_clear");
    chk("dir_dly_zero", 32'(bus.o_zero), 32'd1);
    bus.i_dly_allow = 1'b1;
    for (int i = 0; i < 3; i++) cyc("dly_again");
    bus.i_is_dly_mode = 1'b0;
    bus.i_is_cnt_mode = 1'b0;
    for (int i = 0; i < 2; i++) cyc("no_mode_hold");
    bus.i_keep = 1'b0;

    // Asynchronous reset mid-count
    set_rst(1'b0, "rst6");
    bus.i_reset_set_mode     = 1'b1;
    bus.i_data_from_register = 14'd40;
    bus.i_is_cnt_mode        = 1'b1;
    bus.i_up                 = 1'b1;
    set_rst(1'b1, "rel6");
    cyc("load40");
    for (int i = 0; i < 2; i++) cyc("up40");
    chk("dir_cnt_42", 32'(bus.o_counter), 32'd42);
    #2;
    set_rst(1'b0, "async_clear");
    chk("dir_async_zero", 32'(bus.o_counter), 32'd0);
    bus.i_data_from_register = 14'd7;
    set_rst(1'b1, "rel7");
    cyc("load7");
    chk("dir_load7", 32'(bus.o_counter), 32'd7);
    cyc("up7");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/cnt_dly_counter_core.md
Name: cnt_dly_counter_core

Overview:
Stand-alone main counter stage of the CNT/DLY2/FSM0 macrocell. It consumes the mode-selected counter reset and the DLY/CNT/FSM control strobes, and it produces the counter value that the delay and counter/FSM mode logic compare against. It also adds a post-reset preset-load phase, a keep/hold state, and wrap and terminal flags. The downstream mode blocks use these flags instead of performing their own full-width compares.

Parameters:
- BIT_WIDTH, 14, counter and preset width.

Ports:
- clk, input, 1, selected macrocell clock (output of the clock-source mux); all state updates on posedge.
- main_counter_reset, input, 1, asynchronous, active-low counter reset (mode-selected DLY or CNT reset).
- i_reset_set_mode, input, 1, CNT2 value control (reg<1798>): 0 = reset value 0; 1 = reset value is preset.
- i_data_from_register, input, BIT_WIDTH, preset/reload value D (reg<1787:1774>).
- i_is_dly_mode, input, 1, macrocell in DLY function.
- i_is_cnt_mode, input, 1, macrocell in CNT/FSM function.
- i_dly_allow, input, 1, DLY count enable; 0 clears the counter.
- i_up, input, 1, FSM direction: 1 = up, 0 = down.
- i_keep, input, 1, FSM hold request.
- o_counter, output, BIT_WIDTH, registered counter value.
- o_zero, output, 1, o_counter == 0 (decoded from the register, no extra latency).
- o_match, output, 1, o_counter == D.
- o_wrap, output, 1, one-cycle registered pulse on up-overflow or down-reload.
- o_loaded, output, 1, one-cycle registered pulse on the first clock after reset release.
- o_keeping, output, 1, high while FSM is in KEEP.

Behaviour:
- Reset (main_counter_reset = 0, async):
  - state = ARMED, o_counter = 0, o_wrap = 0, o_loaded = 0, o_keeping = 0.
  - o_zero = 1; o_match follows D.
  - Reset held low means the counter stays frozen regardless of clk.
- ARMED, first posedge after release:
  - o_counter <= i_reset_set_mode ? D : 0; o_loaded <= 1; state <= RUN.
  - i_keep, i_up and i_dly_allow are ignored on this edge.
- RUN, DLY mode (i_is_dly_mode = 1, takes priority over i_is_cnt_mode):
  - o_counter <= i_dly_allow ? o_counter + 1 : 0.
  - Overflow at 2^BIT_WIDTH - 1 wraps to 0 and sets o_wrap <= 1.
  - KEEP is never entered in DLY mode.
- RUN, CNT mode, up (i_up = 1):
  - i_keep = 1: hold, state <= KEEP.
  - else o_counter <= o_counter + 1; all-ones wraps to 0 with o_wrap <= 1.
- RUN, CNT mode, down (i_up = 0):
  - If o_counter == 0: o_counter <= D and o_wrap <= 1. This applies even when i_keep = 1; reload wins over keep, and state stays RUN.
  - Else if i_keep = 1: hold, state <= KEEP.
  - Else o_counter <= o_counter - 1.
- KEEP:
  - Counter holds; o_keeping = 1.
  - i_keep = 0 returns to RUN and applies the RUN rule for the current i_up on that same edge; no dead cycle.
  - Down direction with o_counter == 0 in KEEP: reload to D, o_wrap <= 1, state <= RUN.
  - Leaving CNT mode forces state <= RUN.
- Neither mode flag set (Edge Detect / Wake-Sleep): counter holds; state RUN; no pulses.
- Pulses: o_wrap and o_loaded default to 0 on every edge that does not set them.
- D changes: take effect at the next load or reload only; o_match tracks the live D.
- Reset mid-operation: the async clear wins immediately, and any pending o_wrap/o_loaded pulse is dropped.
- Arithmetic: modulo 2^BIT_WIDTH, unsigned; no saturation.

Test Plan:
- Set mode, D=100, release reset -> first edge: o_counter=100, o_loaded=1 for one cycle; then CNT down yields 99, 98, ...
- CNT down, i_reset_set_mode=0, D=3 -> 0 reloads to 3 with o_wrap pulse, then 2, 1, 0, 3 with o_wrap pulse; period 4 clocks.
- CNT up from 16382 -> 16383, 0 with o_wrap=1 on the 0 cycle, then 1.
- i_keep=1 at counter=5 (down) for 3 clocks -> holds 5, o_keeping=1; keep released -> 4 on the same edge. Keep asserted at counter=0 -> reloads to D anyway, o_wrap=1.
- DLY mode, i_dly_allow=1 for 10 clocks then 0 -> 1..10, then 0; o_zero=1 afterwards.
- Assert main_counter_reset mid-count (counter=42) between edges -> o_counter=0 immediately, state ARMED; release with set mode, D=7 -> next edge 7 with o_loaded pulse.
